iscbdiv_mc: RTL

- Multi-channel in-stream correlated unipolar stochastic divider.
- Each of CH lanes pairs a skewed-sync stage with a CORDIV shift-register kernel.
- The lanes share a clock enable and a windowed ones-counter, which turns the quotient bitstream into a binary estimate.
- Sits between the bitstream generators and downstream unary/binary consumers. It is the multi-lane, stallable, self-measuring successor to the single-lane divider.

---
 rtl/iscbdiv_mc.sv | 97 +++++++++
 1 files changed

// File: rtl/iscbdiv_mc.sv
// iscbdiv_mc: multi-lane correlated stochastic divider (skewed-sync + CORDIV kernel)
// with a shared windowed ones-counter that turns each quotient stream into a binary count.
module iscbdiv_mc #(
    parameter int CH            = 4,
    parameter int DEPLOG_KERNEL = 2,
    parameter int DEP_SYNC      = 2,
    parameter int WINLOG        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [CH*DEPLOG_KERNEL-1:0] randNum,
    input  logic [CH-1:0]               dividend,
    input  logic [CH-1:0]               divisor,
    output logic [CH-1:0]               quotient,
    output logic                        quotient_vld,
    output logic [CH*(WINLOG+1)-1:0]    win_count,
    output logic                        win_done
);
    localparam int DEP_KERNEL = 2 ** DEPLOG_KERNEL;
    localparam int CW = $clog2(DEP_SYNC + 1);
    localparam int WCW = WINLOG + 1;
    localparam logic [CW-1:0] SAT = CW'(DEP_SYNC);

    logic [CW-1:0]         c_q   [CH];
    logic [CW-1:0]         c_d   [CH];
    logic [DEP_KERNEL-1:0] sr_q  [CH];
    logic [DEP_KERNEL-1:0] sr_d  [CH];
    logic [WCW-1:0]        acc_q [CH];
    logic [WCW-1:0]        acc_d [CH];
    logic [WCW-1:0]        wc_q  [CH];
    logic [WCW-1:0]        wc_d  [CH];
    logic [WINLOG-1:0]     w_q, w_d;
    logic [CH-1:0]         quotient_q, d_s, q_next;
    logic                  vld_q, done_q, wrap;

    always_comb begin
        c_d    = c_q;
        sr_d   = sr_q;
        acc_d  = acc_q;
        wc_d   = wc_q;
        d_s    = '0;
        q_next = '0;
        wrap   = &w_q;
        w_d    = w_q + 1'b1;
        for (int i = 0; i < CH; i++) begin
            // Unpaired dividend ones wait in the counter until a divisor one arrives.
            if (dividend[i] && divisor[i]) begin
                d_s[i] = 1'b1;
            end else if (dividend[i]) begin
                d_s[i] = (c_q[i] == SAT);
                if (c_q[i] != SAT) c_d[i] = c_q[i] + 1'b1;
            end else if (divisor[i] && c_q[i] != '0) begin
                d_s[i] = 1'b1;
                c_d[i] = c_q[i] - 1'b1;
            end
            q_next[i] = divisor[i] ? d_s[i] : sr_q[i][randNum[i*DEPLOG_KERNEL +: DEPLOG_KERNEL]];
            sr_d[i]   = {sr_q[i][DEP_KERNEL-2:0], q_next[i]};
            acc_d[i]  = wrap ? '0 : acc_q[i] + WCW'(q_next[i]);
            if (wrap) wc_d[i] = acc_q[i] + WCW'(q_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q        <= '0;
            quotient_q <= '0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                c_q[i]   <= '0;
                sr_q[i]  <= '0;
                acc_q[i] <= '0;
                wc_q[i]  <= '0;
            end
        end else begin
            vld_q  <= en;
            done_q <= en && wrap;
            if (en) begin
                w_q        <= w_d;
                quotient_q <= q_next;
                c_q        <= c_d;
                sr_q       <= sr_d;
                acc_q      <= acc_d;
                wc_q       <= wc_d;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_wc
        assign win_count[g*WCW +: WCW] = wc_q[g];
    end

    assign quotient     = quotient_q;
    assign quotient_vld = vld_q;
    assign win_done     = done_q;
endmodule
